ps2_scancode_controller: RTL and testbench

PS2_SCANCODE_CONTROLLER -- requirements
Module: ps2_scancode_controller

---
 rtl/ps2_scancode_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_ps2_scancode_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_controller.sv
// ps2_scancode_controller
//
// Purpose: turns completed PS/2 receiver frames into key events. Each frame
// is checked for start, stop and odd parity. A small prefix FSM folds the E0
// (extended) and F0 (break) prefixes into flags on the final scan code. The
// resulting event {ext, brk, code} goes into a first-word-fall-through FIFO.
// A pending prefix is abandoned if the final byte does not arrive within
// TIMEOUT_CYCLES.
//
// Ports:
//   clk            system clock (only clock used)
//   reset          synchronous, active-high reset
//   rx_done_tick   one-cycle pulse: rx_frame holds a complete frame
//   rx_frame[10:0] [0] start, [8:1] data LSB-first, [9] parity, [10] stop
//   rx_en          registered receive enable; low while the FIFO is full
//   key_valid      FIFO head holds an event
//   key_code       scan code of the head event
//   key_ext        head event carried an E0 prefix
//   key_break      head event is a release (F0 prefix)
//   key_rd         pop request; ignored while key_valid=0
//   fifo_full      FIFO holds FIFO_DEPTH entries
//   err_frame      pulse: bad start, stop or parity bit
//   err_seq        pulse: illegal prefix sequence
//   err_timeout    pulse: pending prefix sequence abandoned
//   err_overflow   pulse: event dropped because the FIFO was full
//   dbg_state      current prefix FSM state (IDLE=0, EXT=1, BRK=2, EXT_BRK=3)
//
// Handshake: an event is offered while key_valid=1. It is consumed on every
// clock edge where key_valid=1 and key_rd=1. The next head is visible on the
// cycle after that edge. key_rd while key_valid=0 has no effect.

module ps2_scancode_controller #(
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_done_tick,
    input  logic [10:0] rx_frame,
    output logic        rx_en,
    output logic        key_valid,
    output logic [7:0]  key_code,
    output logic        key_ext,
    output logic        key_break,
    input  logic        key_rd,
    output logic        fifo_full,
    output logic        err_frame,
    output logic        err_seq,
    output logic        err_timeout,
    output logic        err_overflow,
    output logic [1:0]  dbg_state
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   to_q, to_d;

    logic [9:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            rx_en_q, rx_en_d;

    logic            err_frame_q, err_frame_d;
    logic            err_seq_q, err_seq_d;
    logic            err_timeout_q, err_timeout_d;
    logic            err_overflow_q, err_overflow_d;

    logic            frame_ok;
    logic [7:0]      rx_byte;
    logic            push_req, push_ext, push_brk;
    logic            full, do_push, do_pop;

    // Odd parity covers the eight data bits plus the parity bit.
    assign frame_ok = ~rx_frame[0] & rx_frame[10] & (^rx_frame[9:1]);
    assign rx_byte  = rx_frame[8:1];

    // ------------------------------------------------------------------
    // Prefix FSM and timeout counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        to_d          = to_q;
        push_req      = 1'b0;
        push_ext      = 1'b0;
        push_brk      = 1'b0;
        err_frame_d   = 1'b0;
        err_seq_d     = 1'b0;
        err_timeout_d = 1'b0;

        // A received byte takes precedence over an expiring timeout.
        if (rx_done_tick) begin
            to_d = '0;
            if (!frame_ok) begin
                err_frame_d = 1'b1;
                state_d     = ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (rx_byte == BYTE_EXT) begin
                            state_d = ST_EXT;
                        end else if (rx_byte == BYTE_BRK) begin
                            state_d = ST_BRK;
                        end else begin
                            push_req = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (rx_byte == BYTE_BRK) begin
                            state_d = ST_EXT_BRK;
                        end else if (rx_byte == BYTE_EXT) begin
                            // Repeated E0 is tolerated; remain extended.
                            state_d = ST_EXT;
                        end else begin
                            push_req = 1'b1;
                            push_ext = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        state_d = ST_IDLE;
                        if (rx_byte == BYTE_EXT || rx_byte == BYTE_BRK) begin
                            err_seq_d = 1'b1;
                        end else begin
                            push_req = 1'b1;
                            push_brk = 1'b1;
                        end
                    end
                    ST_EXT_BRK: begin
                        state_d = ST_IDLE;
                        if (rx_byte == BYTE_EXT || rx_byte == BYTE_BRK) begin
                            err_seq_d = 1'b1;
                        end else begin
                            push_req = 1'b1;
                            push_ext = 1'b1;
                            push_brk = 1'b1;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (state_q == ST_IDLE) begin
            to_d = '0;
        end else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d       = ST_IDLE;
            err_timeout_d = 1'b1;
            to_d          = '0;
        end else begin
            to_d = to_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign do_pop  = key_rd && (count_q != '0);
    // A push while full is accepted only if a pop frees the slot this cycle.
    assign do_push = push_req && (!full || do_pop);

    always_comb begin
        err_overflow_d = push_req && full && !do_pop;
        count_d        = count_q + CW'(do_push) - CW'(do_pop);
        // rx_en reflects the occupancy after this cycle's push and pop.
        rx_en_d        = (count_d < CW'(FIFO_DEPTH));
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            to_q           <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            rx_en_q        <= 1'b0;
            err_frame_q    <= 1'b0;
            err_seq_q      <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            to_q           <= to_d;
            count_q        <= count_d;
            rx_en_q        <= rx_en_d;
            err_frame_q    <= err_frame_d;
            err_seq_q      <= err_seq_d;
            err_timeout_q  <= err_timeout_d;
            err_overflow_q <= err_overflow_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= {push_ext, push_brk, rx_byte};
                // FIFO_DEPTH is a power of two, so pointers wrap naturally.
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rx_en        = rx_en_q;
    assign key_valid    = (count_q != '0);
    assign fifo_full    = full;
    assign key_ext      = mem_q[rd_ptr_q][9];
    assign key_break    = mem_q[rd_ptr_q][8];
    assign key_code     = mem_q[rd_ptr_q][7:0];
    assign err_frame    = err_frame_q;
    assign err_seq      = err_seq_q;
    assign err_timeout  = err_timeout_q;
    assign err_overflow = err_overflow_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ps2_scancode_controller.sv
// Directed testbench for ps2_scancode_controller. Inputs are driven just
// after the falling edge and outputs are sampled at the falling edge, i.e.
// half a cycle after the rising edge that updated them. Expected events are
// queued as {ext, brk, code} in exp_q and compared when the DUT head is popped.

module tb_ps2_scancode_controller;

    localparam int T   = 16;
    localparam int DEP = 4;

    logic        clk;
    logic        reset;
    logic        rx_done_tick;
    logic [10:0] rx_frame;
    logic        rx_en;
    logic        key_valid;
    logic [7:0]  key_code;
    logic        key_ext;
    logic        key_break;
    logic        key_rd;
    logic        fifo_full;
    logic        err_frame;
    logic        err_seq;
    logic        err_timeout;
    logic        err_overflow;
    logic [1:0]  dbg_state;

    int          n_checks;
    int          n_fail;
    logic [9:0]  exp_q[$];

    ps2_scancode_controller #(
        .TIMEOUT_CYCLES(T),
        .FIFO_DEPTH    (DEP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_done_tick(rx_done_tick),
        .rx_frame    (rx_frame),
        .rx_en       (rx_en),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ext     (key_ext),
        .key_break   (key_break),
        .key_rd      (key_rd),
        .fifo_full   (fifo_full),
        .err_frame   (err_frame),
        .err_seq     (err_seq),
        .err_timeout (err_timeout),
        .err_overflow(err_overflow),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    function automatic logic [10:0] mk(input logic [7:0] b);
        return {1'b1, ~(^b), b, 1'b0};
    endfunction

    // One-cycle tick; optional simultaneous pop. Returns at the falling edge
    // after the rising edge that sampled the tick.
    task automatic send_frame(input logic [10:0] f, input logic rd);
        @(negedge clk);
        rx_frame     = f;
        rx_done_tick = 1'b1;
        key_rd       = rd;
        @(negedge clk);
        rx_done_tick = 1'b0;
        key_rd       = 1'b0;
    endtask

    task automatic check_head(input string tag);
        logic [9:0] e;
        check({tag, "_valid"}, 32'(key_valid), 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_expq_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_event"}, {22'd0, key_ext, key_break, key_code}, {22'd0, e});
        end
    endtask

    task automatic pop_check(input string tag);
        check_head(tag);
        key_rd = 1'b1;
        @(negedge clk);
        key_rd = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        rx_frame     = '0;
        key_rd       = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_rx_en",     32'(rx_en),     32'd0);
        check("rst_key_valid", 32'(key_valid), 32'd0);
        check("rst_full",      32'(fifo_full), 32'd0);
        check("rst_errs", 32'({err_frame, err_seq, err_timeout, err_overflow}), 32'd0);
        check("rst_state",     32'(dbg_state), 32'd0);
        check("rst_code",      32'(key_code),  32'd0);
        do_reset();
        @(negedge clk);
        check("rst_rx_en_after", 32'(rx_en), 32'd1);

        // Plain make code, visible the cycle after the tick.
        send_frame(11'h438, 1'b0);
        exp_q.push_back(10'h01C);
        pop_check("make_1c");
        check("make_empty", 32'(key_valid), 32'd0);

        // E0 F0 75 -> one extended break event.
        send_frame(11'h5C0, 1'b0);
        check("e0_state", 32'(dbg_state), 32'd1);
        send_frame(11'h7E0, 1'b0);
        check("e0f0_state", 32'(dbg_state), 32'd3);
        check("e0f0_nopush", 32'(key_valid), 32'd0);
        send_frame(11'h4EA, 1'b0);
        exp_q.push_back(10'h375);
        pop_check("extbrk_75");
        check("extbrk_single", 32'(key_valid), 32'd0);

        // Parity error.
        send_frame(11'h638, 1'b0);
        check("par_err_frame", 32'(err_frame), 32'd1);
        check("par_nopush",    32'(key_valid), 32'd0);
        @(negedge clk);
        check("par_err_pulse", 32'(err_frame), 32'd0);

        // A bad frame also discards a pending prefix.
        send_frame(11'h5C0, 1'b0);
        send_frame(11'h439, 1'b0);  // start bit set
        check("start_err_frame", 32'(err_frame), 32'd1);
        check("start_err_state", 32'(dbg_state), 32'd0);
        send_frame(11'h038, 1'b0);  // stop bit clear
        check("stop_err_frame", 32'(err_frame), 32'd1);
        send_frame(11'h438, 1'b0);
        exp_q.push_back(10'h01C);
        pop_check("after_bad_1c");

        // Fill, overflow, drain.
        for (int i = 0; i < 4; i++) begin
            send_frame(11'h438, 1'b0);
            exp_q.push_back(10'h01C);
        end
        check("fill_full",  32'(fifo_full), 32'd1);
        check("fill_rx_en", 32'(rx_en),     32'd0);
        send_frame(11'h438, 1'b0);
        check("ovf_pulse", 32'(err_overflow), 32'd1);
        check("ovf_full",  32'(fifo_full),    32'd1);
        for (int i = 0; i < 4; i++) pop_check("drain_1c");
        check("drain_empty", 32'(key_valid), 32'd0);
        check("drain_rx_en", 32'(rx_en),     32'd1);
        check("drain_ovf",   32'(err_overflow), 32'd0);

        // Ordering, overflow keeps contents, push+pop while full.
        send_frame(mk(8'h11), 1'b0);
        send_frame(mk(8'h22), 1'b0);
        send_frame(mk(8'h33), 1'b0);
        send_frame(mk(8'h44), 1'b0);
        send_frame(mk(8'h55), 1'b0);
        check("ovf2_pulse", 32'(err_overflow), 32'd1);
        exp_q.push_back(10'h011);
        check_head("fullpop_head_11");
        send_frame(mk(8'h66), 1'b1);
        check("fullpop_no_ovf", 32'(err_overflow), 32'd0);
        check("fullpop_full",   32'(fifo_full),    32'd1);
        check("fullpop_rx_en",  32'(rx_en),        32'd0);
        exp_q.push_back(10'h022);
        exp_q.push_back(10'h033);
        exp_q.push_back(10'h044);
        exp_q.push_back(10'h066);
        for (int i = 0; i < 4; i++) pop_check("order");
        check("order_empty", 32'(key_valid), 32'd0);

        // Timeout after a lone E0.
        send_frame(11'h5C0, 1'b0);
        cyc = 0;
        while (!err_timeout && cyc < 3 * T) begin
            @(negedge clk);
            cyc++;
        end
        check("to_cycles", 32'(cyc),       32'(T));
        check("to_state",  32'(dbg_state), 32'd0);
        send_frame(11'h438, 1'b0);
        exp_q.push_back(10'h01C);
        pop_check("to_then_1c");

        // Tick on the timeout cycle wins.
        send_frame(11'h5C0, 1'b0);
        repeat (T - 2) @(negedge clk);
        check("to_pri_pending", 32'(dbg_state), 32'd1);
        send_frame(11'h438, 1'b0);
        check("to_pri_no_to", 32'(err_timeout), 32'd0);
        exp_q.push_back(10'h21C);
        pop_check("to_pri_ext_1c");

        // E0 E0 stays extended.
        send_frame(11'h5C0, 1'b0);
        send_frame(11'h5C0, 1'b0);
        send_frame(11'h438, 1'b0);
        exp_q.push_back(10'h21C);
        pop_check("e0e0_ext_1c");

        // F0 F0 -> sequence error.
        send_frame(11'h7E0, 1'b0);
        check("f0_state", 32'(dbg_state), 32'd2);
        send_frame(11'h7E0, 1'b0);
        check("f0f0_err_seq", 32'(err_seq),   32'd1);
        check("f0f0_state",   32'(dbg_state), 32'd0);
        check("f0f0_nopush",  32'(key_valid), 32'd0);
        send_frame(11'h438, 1'b0);
        exp_q.push_back(10'h01C);
        pop_check("f0f0_then_1c");

        // Reset mid-sequence and with queued data.
        send_frame(11'h438, 1'b0);
        send_frame(11'h5C0, 1'b0);
        do_reset();
        check("midrst_valid", 32'(key_valid), 32'd0);
        @(negedge clk);
        check("midrst_rx_en", 32'(rx_en), 32'd1);
        send_frame(11'h438, 1'b0);
        exp_q.push_back(10'h01C);
        pop_check("midrst_1c");
        check("midrst_empty", 32'(key_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
